// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex_display_ctrl block: FSM states,
// the hex-to-segment table and page-count helper.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        SHOW   = 2'd1,
        FROZEN = 2'd2
    } disp_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-high segments, bit order g..a, indexed by nibble value 0..F.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int num_pages(input int data_w, input int num_digits);
        return (data_w / 4 + num_digits - 1) / num_digits;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_enc.sv
// One seven-segment digit: nibble plus blank flag to active-low segments.
module hex_digit_enc
    import hex_disp_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : ~SEG_HEX[nib];

endmodule

// File: rtl/hex_display_ctrl.sv
// Paged multi-digit hex display driver with valid/ready load and freeze.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 32,
    parameter int PAGE_TICKS = 50000000,
    localparam int NUM_PAGES = num_pages(DATA_W, NUM_DIGITS),
    localparam int PW        = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    input  logic [DATA_W-1:0]       load_data,
    output logic                    load_ready,
    input  logic                    freeze,
    output logic [7*NUM_DIGITS-1:0] segs,
    output logic [PW-1:0]           page_idx,
    output logic                    shown_valid
);

    localparam int TW   = $clog2(PAGE_TICKS);
    localparam int NNIB = DATA_W / 4;
    localparam int PADW = NUM_PAGES * NUM_DIGITS * 4;
    localparam int NW   = $clog2(NUM_PAGES * NUM_DIGITS + 1);

    disp_state_e                      state, state_nxt;
    logic [DATA_W-1:0]                value;
    logic [TW-1:0]                    tick;
    logic                             accept;
    logic [PADW-1:0]                  padded;
    logic [NUM_DIGITS-1:0][6:0]       seg_nxt;

    assign accept = load_valid & load_ready;
    assign padded = PADW'(value);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BLANK;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BLANK:   if (accept)  state_nxt = SHOW;
            SHOW:    if (freeze)  state_nxt = FROZEN;
            FROZEN:  if (!freeze) state_nxt = SHOW;
            default: state_nxt = BLANK;
        endcase
    end

    always_comb begin
        load_ready = (state != FROZEN);
    end

    // A load takes priority over paging and restarts from page 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value       <= '0;
            page_idx    <= '0;
            tick        <= '0;
            shown_valid <= 1'b0;
        end else if (accept) begin
            value       <= load_data;
            page_idx    <= '0;
            tick        <= '0;
            shown_valid <= 1'b1;
        end else if (state == SHOW && NUM_PAGES > 1) begin
            if (tick == TW'(PAGE_TICKS - 1)) begin
                tick     <= '0;
                page_idx <= (page_idx == PW'(NUM_PAGES - 1)) ? '0 : page_idx + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

`ifdef LZ_BLANK_EN
    logic [NW-1:0] msn;

    always_comb begin
        msn = '0;
        for (int i = 0; i < NNIB; i++)
            if (value[i*4 +: 4] != 4'h0) msn = NW'(i);
    end
`endif

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        logic [NW-1:0] nidx;
        logic [3:0]    nib;
        logic          blank;

        always_comb begin
            nidx  = NW'(page_idx) * NW'(NUM_DIGITS) + NW'(k);
            nib   = 4'(padded >> {nidx, 2'b00});
            blank = (state == BLANK) || (nidx >= NW'(NNIB));
`ifdef LZ_BLANK_EN
            blank = blank || (nidx > msn);
`endif
        end

        hex_digit_enc u_enc (
            .nib   (nib),
            .blank (blank),
            .seg   (seg_nxt[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) segs <= {NUM_DIGITS{SEG_BLANK}};
        else     segs <= seg_nxt;
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized bench for hex_display_ctrl against a cycle-level behavioural model.
module tb_hex_display_ctrl;

    localparam int ND = 4;
    localparam int DW = 32;
    localparam int PT = 4;
    localparam int NP = 2;
    localparam int ST_BLANK = 0, ST_SHOW = 1, ST_FROZEN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        lv, frz, ready, sv;
    logic [31:0] ld;
    logic [27:0] segs;
    logic [0:0]  pidx;

    logic        lv16, frz16, ready16, sv16;
    logic [15:0] ld16;
    logic [27:0] segs16;
    logic [0:0]  pidx16;

    always #5 clk = ~clk;

    hex_display_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .PAGE_TICKS(PT)) dut (
        .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_ready(ready),
        .freeze(frz), .segs(segs), .page_idx(pidx), .shown_valid(sv)
    );

    hex_display_ctrl #(.NUM_DIGITS(4), .DATA_W(16), .PAGE_TICKS(4)) dut16 (
        .clk(clk), .rst(rst), .load_valid(lv16), .load_data(ld16), .load_ready(ready16),
        .freeze(frz16), .segs(segs16), .page_idx(pidx16), .shown_valid(sv16)
    );

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int          m_state, m_page, m_tick;
    logic [31:0] m_val;
    logic        m_shown;
    logic [27:0] m_segs;

    localparam logic [6:0] HEX_HI [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [27:0] render(input logic [31:0] v, input int p);
        logic [27:0] r;
        int msn, n, nib;
        logic blank;
        msn = 0;
        for (int i = 0; i < 8; i++)
            if (((v >> (4 * i)) & 32'hF) != 0) msn = i;
        for (int k = 0; k < ND; k++) begin
            n     = p * ND + k;
            nib   = int'((v >> (4 * n)) & 32'hF);
            blank = (n >= DW / 4);
`ifdef LZ_BLANK_EN
            blank = blank || (n > msn);
`endif
            r[7*k +: 7] = blank ? 7'h7F : ~HEX_HI[nib];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = ST_BLANK; m_page = 0; m_tick = 0;
        m_val = '0; m_shown = 1'b0; m_segs = '1;
    endtask

    // Advance one clock; model follows the same inputs.
    task automatic step();
        logic        acc;
        logic [27:0] sn;
        logic [31:0] ldv;
        int          ns;
        acc = lv && (m_state != ST_FROZEN);
        ldv = ld;
        sn  = (m_state == ST_BLANK) ? '1 : render(m_val, m_page);
        ns  = m_state;
        case (m_state)
            ST_BLANK:  if (acc)  ns = ST_SHOW;
            ST_SHOW:   if (frz)  ns = ST_FROZEN;
            default:   if (!frz) ns = ST_SHOW;
        endcase
        @(posedge clk); #1;
        m_segs = sn;
        if (acc) begin
            m_val = ldv; m_page = 0; m_tick = 0; m_shown = 1'b1;
        end else if (m_state == ST_SHOW) begin
            if (m_tick == PT - 1) begin m_tick = 0; m_page = (m_page + 1) % NP; end
            else m_tick++;
        end
        m_state = ns;
    endtask

    task automatic test_reset();
        rst = 1'b1; lv = 0; frz = 0; ld = '0; lv16 = 0; frz16 = 0; ld16 = '0;
        model_reset();
        #12;
        total++; if (segs !== 28'hFFFFFFF) begin bad++; $display("FAIL reset_segs got=%h want=%h", segs, 28'hFFFFFFF); end
        total++; if (pidx !== 1'b0)  begin bad++; $display("FAIL reset_page got=%0d want=0", pidx); end
        total++; if (sv !== 1'b0)    begin bad++; $display("FAIL reset_shown got=%b want=0", sv); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (segs16 !== 28'hFFFFFFF) begin bad++; $display("FAIL reset_segs16 got=%h want=%h", segs16, 28'hFFFFFFF); end
        @(negedge clk); rst = 1'b0;
        step();
        total++; if (segs !== 28'hFFFFFFF) begin bad++; $display("FAIL blank_after_release got=%h want=%h", segs, 28'hFFFFFFF); end
    endtask

    task automatic test_single_page();
        logic [27:0] exp;
        exp = {7'h79, 7'h24, 7'h08, 7'h0E};
        lv16 = 1'b1; ld16 = 16'h12AF;
        step();
        lv16 = 1'b0;
        step();
        total++; if (segs16 !== exp) begin bad++; $display("FAIL single_segs got=%h want=%h", segs16, exp); end
        total++; if (sv16 !== 1'b1)  begin bad++; $display("FAIL single_shown got=%b want=1", sv16); end
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (pidx16 !== 1'b0 || segs16 !== exp) begin
                bad++; $display("FAIL single_hold page=%0d segs=%h want page=0 segs=%h", pidx16, segs16, exp);
            end
        end
    endtask

    task automatic test_paging();
        lv = 1'b1; ld = 32'hDEADBEEF;
        step();
        lv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            total++; if (pidx !== 1'((i / PT) % NP)) begin
                bad++; $display("FAIL paging_page cyc=%0d got=%0d want=%0d", i, pidx, (i / PT) % NP);
            end
            total++; if (segs !== m_segs) begin bad++; $display("FAIL paging_segs cyc=%0d got=%h want=%h", i, segs, m_segs); end
            step();
        end
        total++; if (segs !== m_segs) begin bad++; $display("FAIL paging_segs_end got=%h want=%h", segs, m_segs); end
    endtask

    task automatic test_freeze();
        int n;
        n = 0;
        while (!(m_page == 1 && m_tick == 2) && n < 20) begin step(); n++; end
        total++; if (n >= 20) begin bad++; $display("FAIL freeze_reach got=timeout want=page1_tick2"); end
        frz = 1'b1;
        step();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL freeze_ready got=%b want=0", ready); end
        lv = 1'b1; ld = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (pidx !== 1'b1 || segs !== m_segs || ready !== 1'b0) begin
                bad++; $display("FAIL freeze_hold page=%0d segs=%h rdy=%b want page=1 segs=%h rdy=0", pidx, segs, ready, m_segs);
            end
        end
        lv = 1'b0; frz = 1'b0;
        n = 0;
        while (pidx !== 1'b0 && n < 10) begin step(); n++; end
        total++; if (n != 2) begin bad++; $display("FAIL freeze_resume got=%0d cycles want=2", n); end
        step();
        total++; if (segs !== render(32'hDEADBEEF, 0)) begin bad++; $display("FAIL freeze_value got=%h want=%h", segs, render(32'hDEADBEEF, 0)); end
    endtask

    task automatic test_load_restart();
        int n;
        n = 0;
        while (m_page != 1 && n < 20) begin step(); n++; end
        total++; if (n >= 20 || pidx !== 1'b1) begin bad++; $display("FAIL restart_reach got=%0d want=1", pidx); end
        lv = 1'b1; ld = 32'h1;
        step();
        lv = 1'b0;
        total++; if (pidx !== 1'b0) begin bad++; $display("FAIL restart_page got=%0d want=0", pidx); end
        for (int i = 1; i <= 4; i++) begin
            step();
            total++; if (pidx !== 1'(i == 4)) begin bad++; $display("FAIL restart_tick step=%0d got=%0d want=%0d", i, pidx, i == 4); end
        end
    endtask

    task automatic test_lz();
        logic [27:0] e0, e1;
        int n;
`ifdef LZ_BLANK_EN
        e0 = {7'h7F, 7'h7F, 7'h7F, 7'h12};
        e1 = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
        e0 = {7'h40, 7'h40, 7'h40, 7'h12};
        e1 = {7'h40, 7'h40, 7'h40, 7'h40};
`endif
        lv = 1'b1; ld = 32'h5;
        step();
        lv = 1'b0;
        step();
        total++; if (segs !== e0) begin bad++; $display("FAIL lz_page0 got=%h want=%h", segs, e0); end
        n = 0;
        while (pidx !== 1'b1 && n < 10) begin step(); n++; end
        step();
        total++; if (segs !== e1) begin bad++; $display("FAIL lz_page1 got=%h want=%h", segs, e1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] last;
        lv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ld = $urandom; last = ld;
            step();
        end
        lv = 1'b0;
        step();
        total++; if (segs !== render(last, 0) || pidx !== 1'b0) begin
            bad++; $display("FAIL b2b_last segs=%h page=%0d want segs=%h page=0", segs, pidx, render(last, 0));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            lv = ($urandom_range(0, 5) == 0);
            ld = $urandom;
            if ($urandom_range(0, 7) == 0) frz = ~frz;
            total++; if (ready !== 1'(m_state != ST_FROZEN)) begin
                bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", i, ready, m_state != ST_FROZEN);
            end
            step();
            total++; if (segs !== m_segs || pidx !== 1'(m_page) || sv !== m_shown) begin
                bad++; $display("FAIL rand_out cyc=%0d segs=%h page=%0d sv=%b want segs=%h page=%0d sv=%b",
                                i, segs, pidx, sv, m_segs, m_page, m_shown);
            end
        end
        lv = 1'b0; frz = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        lv = 1'b1; ld = 32'h00C0FFEE;
        step();
        lv = 1'b0;
        n = 0;
        while (!(m_state == ST_SHOW && m_page == 1) && n < 30) begin step(); n++; end
        total++; if (pidx !== 1'b1) begin bad++; $display("FAIL rstmid_reach got=%0d want=1", pidx); end
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++; if (segs !== 28'hFFFFFFF || pidx !== 1'b0 || sv !== 1'b0) begin
            bad++; $display("FAIL rstmid_async segs=%h page=%0d sv=%b want all-ones/0/0", segs, pidx, sv);
        end
        @(negedge clk); rst = 1'b0;
        step();
        total++; if (segs !== 28'hFFFFFFF || ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_after segs=%h rdy=%b want all-ones/1", segs, ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_page();
        test_paging();
        test_freeze();
        test_load_restart();
        test_lz();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Parametrised successor to the fixed 4-digit hex readout on the FPGA top level. It accepts a DATA_W-bit value through a valid/ready load port and drives NUM_DIGITS seven-segment digits. When the value has more nibbles than there are digits, it auto-scrolls through pages on a programmable tick, and a freeze input holds the current page. It sits between any datapath result (FSM/ALU output) and the board HEX pins.

Parameters:
NUM_DIGITS, 4, number of physical 7-seg digits driven.
DATA_W, 32, width of the displayed value; must be a multiple of 4 and at least 4*NUM_DIGITS.
PAGE_TICKS, 50000000, clock cycles each page is shown before advancing; must be at least 2.
NUM_PAGES, derived localparam = ceil(DATA_W/4 / NUM_DIGITS).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
load_valid  in  1  new value offered
load_data  in  DATA_W  value to display
load_ready  out  1  block can accept a value
freeze  in  1  hold the current page and refuse loads
segs  out  7*NUM_DIGITS  active-low segments; digit k occupies bits [7k+6:7k]; bit 7k = seg a ... bit 7k+6 = seg g; digit 0 is rightmost
page_idx  out  clog2(NUM_PAGES) (min 1)  index of the page currently shown
shown_valid  out  1  a value has been loaded since reset

Behaviour:
- Reset is async and active-high. While asserted and on release:
  - state=BLANK, value reg=0, page_idx=0, tick counter=0.
  - segs all 1 (blank), shown_valid=0, load_ready=1.
- FSM states and transitions:
  - BLANK -> SHOW on an accepted load.
  - SHOW -> FROZEN when freeze=1.
  - FROZEN -> SHOW when freeze=0.
  - No path returns to BLANK except reset.
- load_ready = (state != FROZEN); it is combinational from the state only and never from load_valid.
- Load acceptance = load_valid & load_ready, sampled at the clock edge. On the following edge:
  - value latched, page_idx=0, tick=0, shown_valid=1.
  - A load in SHOW restarts paging from page 0.
  - Back-to-back accepts every cycle are legal; the last one wins.
- Paging, only in SHOW and only when NUM_PAGES>1:
  - tick increments each cycle.
  - At tick==PAGE_TICKS-1: tick clears and page_idx increments, wrapping NUM_PAGES-1 -> 0.
  - When NUM_PAGES==1, tick stays at 0 and page_idx stays 0.
- FROZEN: tick and page_idx hold their values. Leaving FROZEN resumes counting from the held tick value.
- Simultaneous freeze rising and load_valid in SHOW: the load is accepted (ready is still 1 that cycle), then the state moves to FROZEN.
- Page p shows nibbles [p*NUM_DIGITS .. p*NUM_DIGITS+NUM_DIGITS-1]. Nibbles beyond DATA_W/4 on the last page are blank.
- segs is registered, with 1-cycle latency from a value/page_idx change to a segs change. In BLANK, segs are all ones.
- Hex encoding (active high before inversion, bits g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001

Optional Feature:
Macro LZ_BLANK_EN.
- Defined: leading-zero blanking. Each digit whose nibble index is above the index of the most significant nonzero nibble of the whole value is blanked. Nibble 0 is always shown, so value 0 shows a single "0" on page 0. A page made up entirely of blanked digits is still visited while paging.
- Undefined: all digits are always shown, including zeros.

Decomposition:
- Package hex_disp_pkg holds:
  - the state enum (BLANK, SHOW, FROZEN);
  - the 16-entry segment constant table;
  - a function computing NUM_PAGES;
  - the SEG_BLANK constant (7'h7F).
- One combinational sub-module, hex_digit_enc (nibble + blank flag -> 7 active-low segments), instantiated NUM_DIGITS times in a generate loop.

Test Plan:
- Reset mid-operation: assert rst while in SHOW at page 1 -> segs go all ones, page_idx=0, shown_valid=0 without waiting for a clock edge.
- Basic load, NUM_DIGITS=4, DATA_W=16: load 16'h12AF -> two cycles later segs digits 3..0 = "1","2","A","F" (active-low 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110 as g..a); page_idx stays 0 forever.
- Paging, DATA_W=32, PAGE_TICKS=4: load 32'hDEADBEEF -> page 0 shows BEEF for 4 cycles, then page 1 shows dEAd, then back to page 0.
- Freeze: assert freeze at page 1 with tick=2 -> load_ready=0, a load of 32'h0 is ignored, page holds; deassert -> page 0 appears after exactly 2 more cycles.
- Load restart: load 32'h1 while on page 1 -> next cycle page_idx=0, tick=0.
- LZ_BLANK_EN defined, load 32'h00000005 -> page 0 shows blank, blank, blank, "5"; page 1 is fully blank. Undefined -> "0005" and "0000".
